// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the MEM stage
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Unknown size code 2'b11 is held to word alignment.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MEM_BYTE: return 1'b1;
            MEM_HALF: return ~addr_lo[0];
            default:  return addr_lo == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// rtl/mem_access_stage_load_formatter.sv - lane select and sign/zero extension of load data
module load_formatter
    import mem_pkg::*;
#(
    parameter int B = 32
) (
    input  logic [B-1:0] rdata_i,
    input  logic [1:0]   addr_lo_i,
    input  logic [1:0]   size_i,
    input  logic         unsigned_i,
    output logic [B-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = rdata_i;
        case (size_i)
            MEM_BYTE: data_o = unsigned_i ? {{(B-8){1'b0}}, byte_sel}
                                          : {{(B-8){byte_sel[7]}}, byte_sel};
            MEM_HALF: data_o = unsigned_i ? {{(B-16){1'b0}}, half_sel}
                                          : {{(B-16){half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory req/ack access, stall, WB register
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int B           = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [B-1:0] alu_result,
    input  logic [B-1:0] store_data,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_size,
    input  logic         mem_unsigned,
    input  logic         reg_write,
    input  logic [4:0]   write_reg,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [B-1:0] dmem_addr,
    output logic [B-1:0] dmem_wdata,
    output logic [3:0]   dmem_be,
    input  logic [B-1:0] dmem_rdata,
    input  logic         dmem_ack,
    output logic         stall,
    output logic         wb_valid,
    output logic         wb_reg_write,
    output logic [4:0]   wb_reg,
    output logic [B-1:0] wb_data,
    output logic         mem_err
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    state_e       state_q;
    logic [B-1:0] req_addr_q, req_wdata_q;
    logic [3:0]   req_be_q;
    logic [1:0]   req_size_q;
    logic         req_we_q, req_unsigned_q, req_reg_write_q;
    logic [4:0]   req_reg_q;
    logic [CW-1:0] cnt_q;
    logic         wb_valid_q, wb_reg_write_q, mem_err_q;
    logic [4:0]   wb_reg_q;
    logic [B-1:0] wb_data_q;

    logic         in_wait, is_mem, illegal, aligned, start, timeout;
    logic [3:0]   st_be;
    logic [B-1:0] st_wdata, load_data, cur_addr;
    logic [1:0]   cur_size;
    logic         cur_unsigned;

    // mem_read together with mem_write is an illegal encoding and runs as a nop.
    assign illegal = mem_read & mem_write;
    assign is_mem  = mem_read ^ mem_write;
    assign aligned = is_aligned(mem_size, alu_result[1:0]);
    assign in_wait = (state_q == ST_WAIT);
    assign start   = (state_q == ST_IDLE) & in_valid & is_mem & aligned;
    assign timeout = in_wait & ~dmem_ack & (ACK_TIMEOUT != 0) & (cnt_q == CNT_LAST);

    always_comb begin
        st_be    = BE_WORD;
        st_wdata = store_data;
        case (mem_size)
            MEM_BYTE: begin
                st_be    = BE_BYTE0 << alu_result[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            MEM_HALF: begin
                st_be    = alu_result[1] ? BE_HALF_HI : BE_HALF_LO;
                st_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign cur_addr     = in_wait ? req_addr_q     : alu_result;
    assign cur_size     = in_wait ? req_size_q     : mem_size;
    assign cur_unsigned = in_wait ? req_unsigned_q : mem_unsigned;

    // Gated by rst_n so the bus goes quiet the moment reset asserts, even mid-access.
    assign dmem_req   = rst_n & (start | in_wait);
    assign dmem_we    = dmem_req & (in_wait ? req_we_q : mem_write);
    assign dmem_addr  = dmem_req ? {cur_addr[B-1:2], 2'b00} : '0;
    assign dmem_be    = dmem_req ? (in_wait ? req_be_q : st_be) : 4'b0000;
    assign dmem_wdata = dmem_req ? (in_wait ? req_wdata_q : st_wdata) : '0;
    assign stall      = dmem_req & ~dmem_ack;

    load_formatter #(.B(B)) u_load_formatter (
        .rdata_i    (dmem_rdata),
        .addr_lo_i  (cur_addr[1:0]),
        .size_i     (cur_size),
        .unsigned_i (cur_unsigned),
        .data_o     (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            req_be_q        <= '0;
            req_size_q      <= '0;
            req_we_q        <= 1'b0;
            req_unsigned_q  <= 1'b0;
            req_reg_write_q <= 1'b0;
            req_reg_q       <= '0;
            cnt_q           <= '0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_reg_q        <= '0;
            wb_data_q       <= '0;
            mem_err_q       <= 1'b0;
        end else begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            mem_err_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        wb_reg_q <= write_reg;
                        if (!is_mem) begin
                            wb_valid_q     <= 1'b1;
                            wb_reg_write_q <= reg_write & ~illegal;
                            wb_data_q      <= alu_result;
                        end else if (!aligned) begin
                            wb_valid_q <= 1'b1;
                            mem_err_q  <= 1'b1;
                            wb_data_q  <= '0;
                        end else if (dmem_ack) begin
                            wb_valid_q     <= 1'b1;
                            wb_reg_write_q <= reg_write & ~mem_write;
                            wb_data_q      <= mem_write ? '0 : load_data;
                        end else begin
                            state_q         <= ST_WAIT;
                            cnt_q           <= '0;
                            req_addr_q      <= alu_result;
                            req_wdata_q     <= st_wdata;
                            req_be_q        <= st_be;
                            req_size_q      <= mem_size;
                            req_we_q        <= mem_write;
                            req_unsigned_q  <= mem_unsigned;
                            req_reg_write_q <= reg_write;
                            req_reg_q       <= write_reg;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        state_q        <= ST_IDLE;
                        wb_valid_q     <= 1'b1;
                        wb_reg_q       <= req_reg_q;
                        wb_reg_write_q <= req_reg_write_q & ~req_we_q;
                        wb_data_q      <= req_we_q ? '0 : load_data;
                    end else if (timeout) begin
                        state_q    <= ST_IDLE;
                        wb_valid_q <= 1'b1;
                        wb_reg_q   <= req_reg_q;
                        mem_err_q  <= 1'b1;
                        wb_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_reg       = wb_reg_q;
    assign wb_data      = wb_data_q;
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] alu_result = '0, store_data = '0, dmem_rdata = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0, reg_write = 1'b0;
    logic [1:0]  mem_size = '0;
    logic [4:0]  write_reg = '0;
    logic        dmem_ack = 1'b0;
    logic        dmem_req, dmem_we, stall, wb_valid, wb_reg_write, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_reg;

    always #5 clk = ~clk;

    mem_access_stage #(.B(32), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .reg_write(reg_write),
        .write_reg(write_reg), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_reg(wb_reg),
        .wb_data(wb_data), .mem_err(mem_err)
    );

    typedef struct {
        logic [31:0] alu, sd;
        logic        mr, mw;
        logic [1:0]  size;
        logic        uns, rw;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we, rw;
        logic [31:0] data;
        logic        chk, err;
    } exp_t;

    typedef struct {
        op_t         op;
        int          dly;
        logic [31:0] rdata;
        exp_t        e;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic op_t mk_op(input logic [31:0] alu, input logic [31:0] sd, input logic mr,
                                  input logic mw, input logic [1:0] size, input logic uns,
                                  input logic rw, input logic [4:0] rd);
        op_t o;
        o.alu = alu; o.sd = sd; o.mr = mr; o.mw = mw;
        o.size = size; o.uns = uns; o.rw = rw; o.rd = rd;
        return o;
    endfunction

    function automatic exp_t mk_exp(input logic req, input logic [31:0] addr, input logic [3:0] be,
                                    input logic [31:0] wdata, input logic we, input logic rw,
                                    input logic [31:0] data, input logic chk, input logic err);
        exp_t e;
        e.req = req; e.addr = addr; e.be = be; e.wdata = wdata; e.we = we;
        e.rw = rw; e.data = data; e.chk = chk; e.err = err;
        return e;
    endfunction

    function automatic vec_t mk_vec(input op_t o, input int dly, input logic [31:0] rdata, input exp_t e);
        vec_t v;
        v.op = o; v.dly = dly; v.rdata = rdata; v.e = e;
        return v;
    endfunction

    // Reference model: bus fields and WB result from plain arithmetic on the op.
    function automatic exp_t model(input op_t o, input logic [31:0] rdata, input int dly);
        exp_t        e;
        int          lo;
        bit          mem, ok;
        logic [31:0] v;
        lo  = int'(o.alu[1:0]);
        mem = (o.mr != o.mw);
        ok  = (o.size == 2'd0) || (o.size == 2'd1 && lo % 2 == 0) || (lo == 0);
        e = mk_exp(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        e.req   = mem && ok;
        e.addr  = o.alu & 32'hFFFF_FFFC;
        e.we    = o.mw;
        e.be    = (o.size == 2'd0) ? 4'(1 << lo) : (o.size == 2'd1) ? ((lo >= 2) ? 4'hC : 4'h3) : 4'hF;
        e.wdata = (o.size == 2'd0) ? (o.sd & 32'hFF) * 32'h0101_0101
                : (o.size == 2'd1) ? (o.sd & 32'hFFFF) * 32'h0001_0001 : o.sd;
        if (o.size == 2'd0) begin
            v = (rdata >> (8 * lo)) & 32'hFF;
            if (!o.uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (o.size == 2'd1) begin
            v = (rdata >> (8 * (lo & 2))) & 32'hFFFF;
            if (!o.uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        if (!mem) begin
            e.rw = o.rw && !(o.mr && o.mw); e.data = o.alu; e.chk = !(o.mr && o.mw);
        end else if (!ok || dly < 0 || dly > TO) begin
            e.err = 1'b1;
        end else if (o.mr) begin
            e.rw = o.rw; e.data = v; e.chk = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input op_t o);
        alu_result = o.alu; store_data = o.sd; mem_read = o.mr; mem_write = o.mw;
        mem_size = o.size; mem_unsigned = o.uns; reg_write = o.rw; write_reg = o.rd;
    endtask

    task automatic scramble();
        alu_result = $urandom; store_data = $urandom;
        mem_read = 1'($urandom); mem_write = 1'($urandom); mem_size = 2'($urandom);
        mem_unsigned = 1'($urandom); reg_write = 1'($urandom); write_reg = 5'($urandom);
    endtask

    task automatic run_op(input string name, input op_t o, input int dly,
                          input logic [31:0] rdata, input exp_t e);
        int k;
        bit done;
        k = 0;
        done = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; drive(o); dmem_rdata = rdata; dmem_ack = (dly == 0);
        while (!done) begin
            @(negedge clk);
            if (k == 0) check({name, "/prev_wb"}, {wb_valid, mem_err}, 2'b00);
            check({name, "/req_stall"}, {dmem_req, stall}, {e.req, e.req && (k != dly)});
            if (e.req)
                check({name, "/bus"}, {dmem_we, dmem_be, dmem_addr, dmem_wdata},
                      {e.we, e.be, e.addr, e.wdata});
            if (!e.req || k == dly || k == TO) begin
                done = 1;
            end else begin
                @(posedge clk); #1;
                k++;
                scramble();
                dmem_ack = (k == dly);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; dmem_ack = 1'($urandom); scramble();
        @(negedge clk);
        check({name, "/wb"}, {wb_valid, wb_reg_write, wb_reg, mem_err, dmem_req, stall},
              {1'b1, e.rw, o.rd, e.err, 2'b00});
        if (e.chk) check({name, "/wb_data"}, wb_data, e.data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        op_t         o;
        exp_t        e;
        int          dly, sel;
        logic [31:0] rd;

        vecs.push_back(mk_vec(mk_op(32'h42, 0, 0, 0, 2'd0, 0, 1, 5), 2, 32'h0,
                              mk_exp(0, 0, 0, 0, 0, 1, 32'h42, 1, 0)));
        vecs.push_back(mk_vec(mk_op(32'h103, 0, 1, 0, 2'd0, 0, 1, 7), 3, 32'h80FF_1234,
                              mk_exp(1, 32'h100, 4'b1000, 0, 0, 1, 32'hFFFF_FF80, 1, 0)));
        vecs.push_back(mk_vec(mk_op(32'h103, 0, 1, 0, 2'd0, 1, 1, 7), 3, 32'h80FF_1234,
                              mk_exp(1, 32'h100, 4'b1000, 0, 0, 1, 32'h0000_0080, 1, 0)));
        vecs.push_back(mk_vec(mk_op(32'h206, 32'h1234_ABCD, 0, 1, 2'd1, 0, 1, 9), 1, 32'h0,
                              mk_exp(1, 32'h204, 4'b1100, 32'hABCD_ABCD, 1, 0, 0, 0, 0)));
        vecs.push_back(mk_vec(mk_op(32'h101, 0, 1, 0, 2'd2, 0, 1, 3), 1, 32'h0,
                              mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk_vec(mk_op(32'h300, 32'h55, 1, 0, 2'd2, 0, 1, 4), -1, 32'h0,
                              mk_exp(1, 32'h300, 4'hF, 32'h55, 0, 0, 0, 0, 1)));
        vecs.push_back(mk_vec(mk_op(32'h402, 0, 1, 0, 2'd1, 1, 1, 10), 0, 32'h9876_5432,
                              mk_exp(1, 32'h400, 4'b1100, 0, 0, 1, 32'h0000_9876, 1, 0)));
        vecs.push_back(mk_vec(mk_op(32'h402, 0, 1, 0, 2'd1, 0, 1, 10), 0, 32'h9876_5432,
                              mk_exp(1, 32'h400, 4'b1100, 0, 0, 1, 32'hFFFF_9876, 1, 0)));
        vecs.push_back(mk_vec(mk_op(32'h501, 32'hAABB_CC77, 0, 1, 2'd0, 0, 0, 0), 2, 32'h0,
                              mk_exp(1, 32'h500, 4'b0010, 32'h7777_7777, 1, 0, 0, 0, 0)));
        vecs.push_back(mk_vec(mk_op(32'h600, 32'hDEAD_BEEF, 0, 1, 2'd2, 0, 1, 1), 4, 32'h0,
                              mk_exp(1, 32'h600, 4'hF, 32'hDEAD_BEEF, 1, 0, 0, 0, 0)));
        vecs.push_back(mk_vec(mk_op(32'h800, 0, 1, 0, 2'd2, 0, 1, 31), 4, 32'hCAFE_F00D,
                              mk_exp(1, 32'h800, 4'hF, 0, 0, 1, 32'hCAFE_F00D, 1, 0)));
        vecs.push_back(mk_vec(mk_op(32'h900, 0, 1, 1, 2'd2, 0, 1, 6), 1, 32'h0,
                              mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk_vec(mk_op(32'h703, 0, 1, 0, 2'd1, 0, 1, 2), 1, 32'h0,
                              mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 1)));
        vecs.push_back(mk_vec(mk_op(32'h104, 0, 1, 0, 2'd0, 0, 1, 8), 1, 32'h80FF_1234,
                              mk_exp(1, 32'h104, 4'b0001, 0, 0, 1, 32'h0000_0034, 1, 0)));
        vecs.push_back(mk_vec(mk_op(32'hA00, 0, 1, 0, 2'd1, 0, 1, 12), 2, 32'h1234_8001,
                              mk_exp(1, 32'hA00, 4'b0011, 0, 0, 1, 32'hFFFF_8001, 1, 0)));

        // Reset with a live-looking mem op on the inputs: everything must stay quiet.
        in_valid = 1'b1; mem_read = 1'b1; alu_result = 32'h124; mem_size = 2'd2;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, stall,
               wb_valid, wb_reg_write, wb_reg, wb_data, mem_err}, '0);
        in_valid = 1'b0;
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].dly, vecs[i].rdata, vecs[i].e);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            o.alu = $urandom; o.sd = $urandom;
            if ($urandom_range(0, 1) == 1) o.alu[1:0] = 2'b00;
            o.mr = (sel <= 3) || (sel == 9);
            o.mw = (sel >= 4 && sel <= 6) || (sel == 9);
            o.size = 2'($urandom_range(0, 2));
            o.uns = 1'($urandom); o.rw = 1'($urandom); o.rd = 5'($urandom);
            dly = $urandom_range(0, 6);
            rd = $urandom;
            e = model(o, rd, dly);
            run_op($sformatf("rand%0d", i), o, dly, rd, e);
        end

        // Async reset mid-WAIT, followed by a stray ack.
        @(posedge clk); #1;
        in_valid = 1'b1; drive(mk_op(32'hB00, 0, 1, 0, 2'd2, 0, 1, 13)); dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre", {dmem_req, stall}, 2'b11);
        #2 rst_n = 1'b0;
        #1 check("rst_drop", {dmem_req, stall, wb_valid, mem_err}, 4'b0000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst_late_ack%0d", i), {wb_valid, mem_err, dmem_req, stall}, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
